// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority arbiter for the shared single-port data memory, with a port-1 starvation counter.
// Define DMEM_ARB_LOCK_EN to add the lock1 input and the locked register used for atomic port-1 sequences.
module dmem_arbiter #(
    parameter int MEM_WORDS  = 256,
    parameter int WAIT_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DMEM_ARB_LOCK_EN
    input  logic        lock1,
`endif
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        rerr0,
    output logic        rerr1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [31:0] mem_data_out
);
    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_MAX   = 4'(WAIT_LIMIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic        rerr0_q, rerr0_d, rerr1_q, rerr1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        locked;

`ifdef DMEM_ARB_LOCK_EN
    logic locked_q, locked_d;
    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    logic        starve, win0, win1, sel_we, sel_in_range;
    logic [31:0] sel_addr, sel_wdata;

    always_comb begin
        starve    = req1 && (wait_cnt_q == WAIT_MAX);
        win1      = !rst && req1 && (locked || starve || !req0);
        win0      = !rst && req0 && !locked && !win1;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        sel_we    = 1'b0;
        if (win0) begin
            sel_addr  = addr0;
            sel_wdata = wdata0;
            sel_we    = we0;
        end else if (win1) begin
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_we    = we1;
        end
        // Bits [1:0] cannot change the outcome because the limit is word-aligned.
        sel_in_range = sel_addr < BYTE_LIMIT;
    end

    assign gnt0         = win0;
    assign gnt1         = win1;
    assign mem_addr     = sel_addr;
    assign mem_data_in  = sel_wdata;
    assign mem_write_en = (win0 || win1) && sel_in_range && sel_we;
    assign mem_read_en  = (win0 || win1) && sel_in_range && !sel_we;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1 || win1 || locked) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
`ifdef DMEM_ARB_LOCK_EN
        locked_d = win1 ? lock1 : locked_q;
`endif
    end

    always_comb begin
        rvalid0_d = win0 && (!sel_we || !sel_in_range);
        rvalid1_d = win1 && (!sel_we || !sel_in_range);
        rerr0_d   = win0 && !sel_in_range;
        rerr1_d   = win1 && !sel_in_range;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rvalid0_d) rdata0_d = sel_in_range ? mem_data_out : 32'd0;
        if (rvalid1_d) rdata1_d = sel_in_range ? mem_data_out : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rerr0_q    <= 1'b0;
            rerr1_q    <= 1'b0;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q   <= 1'b0;
`endif
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rerr0_q    <= rerr0_d;
            rerr1_q    <= rerr1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
`ifdef DMEM_ARB_LOCK_EN
            locked_q   <= locked_d;
`endif
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rerr0   = rerr0_q;
    assign rerr1   = rerr1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized stimulus for dmem_arbiter, compared against a behavioural
// model of the arbitration rules, the word memory and the registered responses. Honours DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;
    localparam int MEM_WORDS  = 256;
    localparam int WAIT_LIMIT = 4;
    localparam int AW         = $clog2(MEM_WORDS);

    logic        clk = 1'b0;
    logic        rst;
`ifdef DMEM_ARB_LOCK_EN
    logic        lock1;
`endif
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_write_en, mem_read_en;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst(rst),
`ifdef DMEM_ARB_LOCK_EN
        .lock1(lock1),
`endif
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rerr0(rerr0), .rerr1(rerr1),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_data_out(mem_data_out)
    );

    // The physical memory the arbiter fronts.
    logic [31:0] hmem [MEM_WORDS];
    assign mem_data_out = hmem[mem_addr[AW+1:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) hmem[i] <= 32'd0;
        end else if (mem_write_en) begin
            hmem[mem_addr[AW+1:2]] <= mem_data_in;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    int          ref_wait = 0;
    bit          ref_locked = 1'b0;
    bit          e_rv0 = 1'b0, e_rv1 = 1'b0, e_re0 = 1'b0, e_re1 = 1'b0;
    logic [31:0] e_rd0 = 32'd0, e_rd1 = 32'd0;
    bit          last_g0, last_g1;

    // Call half a cycle before the rising edge with inputs already driven.
    task automatic step();
        bit          g0, g1, we, inr, lk;
        logic [31:0] a, wd;
        logic [AW-1:0] wi;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (ref_locked) g1 = req1;
            else if (req1 && ref_wait == WAIT_LIMIT) g1 = 1'b1;
            else if (req0) g0 = 1'b1;
            else if (req1) g1 = 1'b1;
        end
        a   = g0 ? addr0 : (g1 ? addr1 : 32'd0);
        wd  = g0 ? wdata0 : (g1 ? wdata1 : 32'd0);
        we  = g0 ? we0 : (g1 ? we1 : 1'b0);
        inr = a < 32'(MEM_WORDS * 4);
        wi  = a[AW+1:2];
        lk  = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lk  = lock1;
`endif
        check_val("gnt0", 32'(gnt0), 32'(g0));
        check_val("gnt1", 32'(gnt1), 32'(g1));
        check_val("mem_addr", mem_addr, a);
        check_val("mem_data_in", mem_data_in, wd);
        check_val("mem_write_en", 32'(mem_write_en), 32'((g0 || g1) && inr && we));
        check_val("mem_read_en", 32'(mem_read_en), 32'((g0 || g1) && inr && !we));
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'd0;
            ref_wait   = 0;
            ref_locked = 1'b0;
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_re0 = 1'b0; e_re1 = 1'b0;
            e_rd0 = 32'd0; e_rd1 = 32'd0;
        end else begin
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_re0 = 1'b0; e_re1 = 1'b0;
            if (g0 && (!inr || !we)) begin
                e_rv0 = 1'b1;
                e_re0 = !inr;
                e_rd0 = inr ? ref_mem[wi] : 32'd0;
            end
            if (g1 && (!inr || !we)) begin
                e_rv1 = 1'b1;
                e_re1 = !inr;
                e_rd1 = inr ? ref_mem[wi] : 32'd0;
            end
            if ((g0 || g1) && inr && we) ref_mem[wi] = wd;
            if (!req1 || g1 || ref_locked) ref_wait = 0;
            else if (ref_wait < WAIT_LIMIT) ref_wait = ref_wait + 1;
`ifdef DMEM_ARB_LOCK_EN
            if (g1) ref_locked = lk;
`endif
        end
        #1;
        check_val("rvalid0", 32'(rvalid0), 32'(e_rv0));
        check_val("rvalid1", 32'(rvalid1), 32'(e_rv1));
        check_val("rerr0", 32'(rerr0), 32'(e_re0));
        check_val("rerr1", 32'(rerr1), 32'(e_re1));
        check_val("rdata0", rdata0, e_rd0);
        check_val("rdata1", rdata1, e_rd1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h400 + 32'($urandom_range(0, 255));
            1:       return $urandom();
            default: return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4; wdata0 = 32'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8; wdata1 = 32'd0;
`ifdef DMEM_ARB_LOCK_EN
        lock1 = 1'b0;
`endif
        step();
        step();
        check_val("rst_gnt0", 32'(gnt0), 32'd0);
        rst = 1'b0;

        // Port 0 write then read-back
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        step();
        we0 = 1'b0;
        step();
        check_val("p0_rd_valid", 32'(rvalid0), 32'd1);
        check_val("p0_rd_data", rdata0, 32'hDEADBEEF);

        // Contention: four port-0 grants, then port 1, repeating
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val("cont_gnt1", 32'(gnt1), 32'(i % 5 == 4));
            step();
        end

        // Out-of-range read on port 1
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h400;
        step();
        check_val("oor_rerr1", 32'(rerr1), 32'd1);
        check_val("oor_rdata1", rdata1, 32'd0);

        // Cross-port coherence
        we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h0000_00A5;
        step();
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        step();
        check_val("xport_rdata0", rdata0, 32'h0000_00A5);

`ifdef DMEM_ARB_LOCK_EN
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8; lock1 = 1'b1;
        step();
        req1 = 1'b0; req0 = 1'b1; addr0 = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("lock_gnt0", 32'(gnt0), 32'd0);
            step();
        end
        req1 = 1'b1; we1 = 1'b1; wdata1 = 32'h1234_5678; lock1 = 1'b0;
        step();
        req1 = 1'b0;
        #1;
        check_val("unlock_gnt0", 32'(gnt0), 32'd1);
        step();
`endif

        // Randomized traffic; ungranted requests are usually held, sometimes changed
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (last_g0 || !req0 || $urandom_range(0, 3) == 0) begin
                req0   = ($urandom_range(0, 3) != 0);
                we0    = $urandom_range(0, 1) == 1;
                addr0  = rnd_addr();
                wdata0 = $urandom();
            end
            if (last_g1 || !req1 || $urandom_range(0, 3) == 0) begin
                req1   = ($urandom_range(0, 3) != 0);
                we1    = $urandom_range(0, 1) == 1;
                addr1  = rnd_addr();
                wdata1 = $urandom();
            end
`ifdef DMEM_ARB_LOCK_EN
            lock1 = ($urandom_range(0, 7) == 0);
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
